// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush and saturating stall/flush event counters.
module idex_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_id,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   input  logic [4:0]       rd_id,
   input  logic             uses_rs1_id,
   input  logic             uses_rs2_id,
   input  logic             RUWr_id,
   input  logic             DMRd_id,
   input  logic             DMWr_id,
   input  logic             ALUASrc_id,
   input  logic             ALUBSrc_id,
   input  logic [3:0]       ALUOp_id,
   input  logic [1:0]       RUDataWrSrc_id,
   input  logic [4:0]       BrOp_id,
   input  logic [XLEN-1:0]  rs1_data_id,
   input  logic [XLEN-1:0]  rs2_data_id,
   input  logic [XLEN-1:0]  imm_id,
   input  logic [XLEN-1:0]  pc_id,
   input  logic             flush_i,
   output logic [4:0]       rs1_ex,
   output logic [4:0]       rs2_ex,
   output logic [4:0]       rd_ex,
   output logic             RUWr_ex,
   output logic             DMRd_ex,
   output logic             DMWr_ex,
   output logic             ALUASrc_ex,
   output logic             ALUBSrc_ex,
   output logic [3:0]       ALUOp_ex,
   output logic [1:0]       RUDataWrSrc_ex,
   output logic [4:0]       BrOp_ex,
   output logic [XLEN-1:0]  rs1_data_ex,
   output logic [XLEN-1:0]  rs2_data_ex,
   output logic [XLEN-1:0]  imm_ex,
   output logic [XLEN-1:0]  pc_ex,
   output logic             valid_ex,
   output logic             stall_o,
   output logic [CNT_W-1:0] load_use_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic             ruwr_q, ruwr_d, dmrd_q, dmrd_d, dmwr_q, dmwr_d;
   logic             alua_q, alua_d, alub_q, alub_d, valid_q, valid_d;
   logic [3:0]       aluop_q, aluop_d;
   logic [1:0]       wrsrc_q, wrsrc_d;
   logic [4:0]       brop_q, brop_d;
   logic [XLEN-1:0]  rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic [XLEN-1:0]  imm_q, imm_d, pc_q, pc_d;
   logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d;
   logic             hazard;

   // Load in EX whose destination is read by the instruction in ID.
   always_comb begin
      hazard  = valid_q & dmrd_q & ruwr_q & valid_id &
                ((uses_rs1_id & (rs1_id == rd_q)) | (uses_rs2_id & (rs2_id == rd_q)));
      stall_o = hazard & ~flush_i;
   end

   always_comb begin
      valid_d    = 1'b0;
      rs1_d      = 5'd0;
      rs2_d      = 5'd0;
      rd_d       = 5'd0;
      ruwr_d     = 1'b0;
      dmrd_d     = 1'b0;
      dmwr_d     = 1'b0;
      alua_d     = 1'b0;
      alub_d     = 1'b0;
      aluop_d    = 4'd0;
      wrsrc_d    = 2'd0;
      brop_d     = 5'd0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      pc_d       = '0;
      lu_cnt_d   = lu_cnt_q;
      fl_cnt_d   = fl_cnt_q;
      if (!flush_i && !hazard) begin
         valid_d    = valid_id;
         rs1_d      = rs1_id;
         rs2_d      = rs2_id;
         rd_d       = rd_id;
         // Forwarding never checks for x0, so suppress writes to it here.
         ruwr_d     = RUWr_id & (rd_id != 5'd0) & valid_id;
         dmrd_d     = DMRd_id & valid_id;
         dmwr_d     = DMWr_id & valid_id;
         brop_d     = valid_id ? BrOp_id : 5'd0;
         alua_d     = ALUASrc_id;
         alub_d     = ALUBSrc_id;
         aluop_d    = ALUOp_id;
         wrsrc_d    = RUDataWrSrc_id;
         rs1_data_d = rs1_data_id;
         rs2_data_d = rs2_data_id;
         imm_d      = imm_id;
         pc_d       = pc_id;
      end
      if (stall_o && (lu_cnt_q != CNT_MAX)) lu_cnt_d = lu_cnt_q + CNT_W'(1);
      if (flush_i && (fl_cnt_q != CNT_MAX)) fl_cnt_d = fl_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         rs1_q      <= 5'd0;
         rs2_q      <= 5'd0;
         rd_q       <= 5'd0;
         ruwr_q     <= 1'b0;
         dmrd_q     <= 1'b0;
         dmwr_q     <= 1'b0;
         alua_q     <= 1'b0;
         alub_q     <= 1'b0;
         aluop_q    <= 4'd0;
         wrsrc_q    <= 2'd0;
         brop_q     <= 5'd0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         lu_cnt_q   <= '0;
         fl_cnt_q   <= '0;
      end else begin
         valid_q    <= valid_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         ruwr_q     <= ruwr_d;
         dmrd_q     <= dmrd_d;
         dmwr_q     <= dmwr_d;
         alua_q     <= alua_d;
         alub_q     <= alub_d;
         aluop_q    <= aluop_d;
         wrsrc_q    <= wrsrc_d;
         brop_q     <= brop_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         pc_q       <= pc_d;
         lu_cnt_q   <= lu_cnt_d;
         fl_cnt_q   <= fl_cnt_d;
      end
   end

   assign valid_ex       = valid_q;
   assign rs1_ex         = rs1_q;
   assign rs2_ex         = rs2_q;
   assign rd_ex          = rd_q;
   assign RUWr_ex        = ruwr_q;
   assign DMRd_ex        = dmrd_q;
   assign DMWr_ex        = dmwr_q;
   assign ALUASrc_ex     = alua_q;
   assign ALUBSrc_ex     = alub_q;
   assign ALUOp_ex       = aluop_q;
   assign RUDataWrSrc_ex = wrsrc_q;
   assign BrOp_ex        = brop_q;
   assign rs1_data_ex    = rs1_data_q;
   assign rs2_data_ex    = rs2_data_q;
   assign imm_ex         = imm_q;
   assign pc_ex          = pc_q;
   assign load_use_cnt   = lu_cnt_q;
   assign flush_cnt      = fl_cnt_q;

endmodule
